// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over a valid/ready channel, holds the instruction.
// Optional macro FETCH_JUMP_EN resolves the j instruction (opcode 2) inside fetch.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetchState_t;

    fetchState_t state;
    fetchState_t nextState;

    logic [31:0] pc;
    logic [31:0] instrReg;
    logic [31:0] instrPcReg;
    logic [31:0] fetchCountReg;
    logic [31:0] pcPlus4;
    logic [31:0] branchOffset;
    logic [31:0] nextPc;
    logic        handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = REQ;
            REQ:     if (imem_req_valid && imem_req_ready) nextState = WAIT;
            WAIT:    if (imem_rsp_valid) nextState = HOLD;
            HOLD:    if (instr_ready) nextState = REQ;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = (state == REQ);
        instr_valid    = (state == HOLD);
    end

    assign handshake    = instr_valid && instr_ready;
    assign pcPlus4      = instrPcReg + 32'd4;
    assign branchOffset = {{14{instrReg[15]}}, instrReg[15:0], 2'b00};

    // Branch/zero only matter at the handshake; the held instruction is stable throughout HOLD.
    always_comb begin
        nextPc = pcPlus4;
`ifdef FETCH_JUMP_EN
        if (instrReg[31:26] == 6'd2) begin
            nextPc = {pcPlus4[31:28], instrReg[25:0], 2'b00};
        end else if (branch && zero) begin
            nextPc = pcPlus4 + branchOffset;
        end
`else
        if (branch && zero) begin
            nextPc = pcPlus4 + branchOffset;
        end
`endif
    end

    // pc only moves at the handshake, so the request address is stable for all of REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= {RESET_PC[31:2], 2'b00};
            instrReg      <= 32'd0;
            instrPcReg    <= {RESET_PC[31:2], 2'b00};
            fetchCountReg <= 32'd0;
        end else begin
            if (state == WAIT && imem_rsp_valid) begin
                instrReg   <= imem_rsp_data;
                instrPcReg <= pc;
            end
            if (handshake) begin
                pc            <= {nextPc[31:2], 2'b00};
                fetchCountReg <= fetchCountReg + 32'd1;
            end
        end
    end

    assign imem_req_addr = pc;
    assign instr         = instrReg;
    assign instr_pc      = instrPcReg;
    assign opcode        = instrReg[31:26];
    assign fetch_count   = fetchCountReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: a memory responder feeds words, a monitor checks
// request addresses, held instructions and fetch_count against a behavioural next-PC model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic [31:0] fetch_count;

    // Second instance exercising the top-of-address-space wrap.
    logic        rst2;
    logic        req2Valid;
    logic        req2Ready;
    logic [31:0] req2Addr;
    logic        rsp2Valid;
    logic [31:0] rsp2Data;
    logic [31:0] instr2;
    logic [31:0] instrPc2;
    logic [5:0]  opcode2;
    logic        instr2Valid;
    logic        instr2Ready;
    logic        branch2;
    logic        zero2;
    logic [31:0] fetchCount2;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr(instr), .instr_pc(instr_pc), .opcode(opcode),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch(branch), .zero(zero), .fetch_count(fetch_count)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .rst(rst2),
        .imem_req_valid(req2Valid), .imem_req_ready(req2Ready), .imem_req_addr(req2Addr),
        .imem_rsp_valid(rsp2Valid), .imem_rsp_data(rsp2Data),
        .instr(instr2), .instr_pc(instrPc2), .opcode(opcode2),
        .instr_valid(instr2Valid), .instr_ready(instr2Ready),
        .branch(branch2), .zero(zero2), .fetch_count(fetchCount2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;
    int totalConsumed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents, filled lazily with a mix of lw, beq, j and R-type words.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] genWord();
        logic [15:0] imm;
        imm = 16'($urandom_range(0, 16)) - 16'd8;
        case ($urandom_range(0, 3))
            0:       return {6'd35, 26'($urandom)};
            1:       return {6'd4, 10'($urandom), imm};
            2:       return {6'd2, 26'($urandom)};
            default: return {6'd0, 26'($urandom)};
        endcase
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = genWord();
        return mem[a];
    endfunction

    // Next fetch address from the architectural rules of beq / j / sequential flow.
    function automatic logic [31:0] expectNext(input logic [31:0] pcHeld, input logic [31:0] w,
                                               input logic br, input logic zr);
        logic [31:0] p4;
        int off;
        p4  = pcHeld + 32'd4;
        off = $signed(w[15:0]);
`ifdef FETCH_JUMP_EN
        if (w[31:26] == 6'd2) return (p4 & 32'hF000_0000) + (w & 32'h03FF_FFFF) * 4;
`endif
        if (br && zr) return p4 + 32'(off * 4);
        return p4;
    endfunction

    logic [31:0] rspQ[$];

    // Memory responder and consumer stimulus.
    bit          pending = 0;
    bit          rspIssued = 0;
    logic [31:0] pendAddr;
    logic [31:0] curData;
    int          delay;

    initial begin
        bit          willAccept;
        bit          willRsp;
        logic [31:0] acceptAddr;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        instr_ready    = 1'b0;
        branch         = 1'b0;
        zero           = 1'b0;
        forever begin
            @(negedge clk);
            willAccept = imem_req_valid && imem_req_ready;
            acceptAddr = imem_req_addr;
            willRsp    = pending && imem_rsp_valid;
            @(posedge clk);
            #2;
            if (rst) begin
                pending        = 0;
                imem_rsp_valid = 1'b0;
                imem_req_ready = 1'b0;
                instr_ready    = 1'b0;
                continue;
            end
            if (willRsp) pending = 0;
            if (willAccept) begin
                pending   = 1;
                rspIssued = 0;
                pendAddr  = acceptAddr;
                delay     = $urandom_range(0, 3);
            end
            if (pending) begin
                if (delay == 0) begin
                    if (!rspIssued) begin
                        curData = memWord(pendAddr);
                        rspQ.push_back(curData);
                        rspIssued = 1;
                    end
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = curData;
                end else begin
                    delay--;
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = $urandom;
                end
            end else begin
                // Stray pulses outside WAIT must be ignored by the design.
                imem_rsp_valid = ($urandom_range(0, 3) == 0);
                imem_rsp_data  = $urandom;
            end
            imem_req_ready = ($urandom_range(0, 9) < 7);
            instr_ready    = ($urandom_range(0, 9) < 6);
            branch         = 1'($urandom_range(0, 1));
            zero           = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares every presented request / held instruction against the model.
    initial begin
        logic [31:0] modelPc;
        logic [31:0] modelCount;
        logic [31:0] heldWord;
        bit          haveHeld;
        modelPc    = 32'd0;
        modelCount = 32'd0;
        heldWord   = 32'd0;
        haveHeld   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                modelPc    = 32'd0;
                modelCount = 32'd0;
                haveHeld   = 0;
                rspQ.delete();
                continue;
            end
            if (imem_req_valid) chk("req_addr", imem_req_addr, modelPc);
            if (instr_valid) begin
                if (!haveHeld) begin
                    if (rspQ.size() == 0) begin
                        chk("sb_empty", 32'(rspQ.size()), 32'd1);
                        heldWord = 32'hxxxx_xxxx;
                    end else begin
                        heldWord = rspQ.pop_front();
                    end
                    haveHeld = 1;
                end
                chk("instr", instr, heldWord);
                chk("opcode", 32'(opcode), 32'(heldWord[31:26]));
                chk("instr_pc", instr_pc, modelPc);
                chk("fetch_count", fetch_count, modelCount);
                if (instr_ready) begin
                    modelPc = expectNext(modelPc, heldWord, branch, zero);
                    modelCount++;
                    totalConsumed++;
                    haveHeld = 0;
                end
            end
        end
    end

    task automatic applyReset(input string tag);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_fetch_count"}, fetch_count, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_opcode"}, 32'(opcode), 32'd0);
        chk({tag, "_instr_pc"}, instr_pc, 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Directed wrap check on the RESET_PC = 0xFFFFFFFC instance.
    initial begin
        bit seen;
        rst2 = 1'b1;
        req2Ready = 1'b0;
        rsp2Valid = 1'b0;
        rsp2Data = 32'd0;
        instr2Ready = 1'b0;
        branch2 = 1'b0;
        zero2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("wrap_rst_addr", req2Addr, 32'hFFFF_FFFC);
        chk("wrap_rst_pc", instrPc2, 32'hFFFF_FFFC);
        @(posedge clk);
        #1 rst2 = 1'b0;
        req2Ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req2Valid) begin
                seen = 1;
                break;
            end
        end
        chk("wrap_req_seen", 32'(seen), 32'd1);
        chk("wrap_first_addr", req2Addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1 req2Ready = 1'b0;
        rsp2Valid = 1'b1;
        rsp2Data  = 32'h8C01_0004;
        @(posedge clk);
        #1 rsp2Valid = 1'b0;
        @(negedge clk);
        chk("wrap_instr_valid", 32'(instr2Valid), 32'd1);
        chk("wrap_instr_pc", instrPc2, 32'hFFFF_FFFC);
        chk("wrap_opcode", 32'(opcode2), 32'd35);
        instr2Ready = 1'b1;
        @(posedge clk);
        #1 instr2Ready = 1'b0;
        @(negedge clk);
        chk("wrap_req_valid", 32'(req2Valid), 32'd1);
        chk("wrap_next_addr", req2Addr, 32'h0000_0000);
        chk("wrap_fetch_count", fetchCount2, 32'd1);
    end

    initial begin
        bit found;
        rst = 1'b1;
        mem[32'h0]  = 32'h8C01_0004;
        mem[32'h4]  = 32'h0022_1820;
        mem[32'h8]  = 32'h0022_1820;
        mem[32'hC]  = 32'h0022_1820;
        mem[32'h10] = 32'h1022_FFFF;
        mem[32'h40] = 32'h0800_0010;
        repeat (2) @(posedge clk);
        applyReset("rst0");

        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pending && fetch_count >= 32'd3) begin
                found = 1;
                break;
            end
        end
        chk("reach_wait", 32'(found), 32'd1);
        applyReset("rstWait");

        repeat (800) @(posedge clk);
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                found = 1;
                break;
            end
        end
        chk("reach_hold", 32'(found), 32'd1);
        applyReset("rstHold");

        repeat (3000) @(posedge clk);
        chk("progress", 32'(totalConsumed >= 100), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
